// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter: requester count,
// select width, arbiter states and a one-hot helper.
package mux8_rr_arbiter_pkg;

   localparam int NREQ = 8;
   localparam int SELW = 3;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Mux8Way16: the existing shared 16-bit 8:1 datapath multiplexer.
module Mux8Way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   always_comb begin
      case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: finds the first asserted request scanning start, start+1, ... start+7 (mod 8).
module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] start,
   output logic [SELW-1:0] idx,
   output logic            found
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;

   always_comb begin
      // Rotate so that bit 0 of rot corresponds to the requester at start.
      dbl   = {req, req} >> start;
      rot   = dbl[NREQ-1:0];
      idx   = '0;
      found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx   = start + SELW'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one Mux8Way16 among 8 requesters, with bounded bursts
// and a registered output word plus valid flag.
module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d4,
   input  logic [WIDTH-1:0] d5,
   input  logic [WIDTH-1:0] d6,
   input  logic [WIDTH-1:0] d7,
   output logic [7:0]       gnt,
   output logic [2:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   arb_state_t       state_q, state_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       last_q, last_d;
   logic [3:0]       burst_cnt_q, burst_cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic [2:0]       idx_idle, idx_next;
   logic             found_idle, found_next;
   logic [WIDTH-1:0] mux_out;

   rr_pick8 u_pick_idle (
      .req   (req),
      .start (last_q + 3'd1),
      .idx   (idx_idle),
      .found (found_idle)
   );

   // Current holder is masked out, so found_next means "someone else is waiting".
   rr_pick8 u_pick_next (
      .req   (req & ~gnt_q),
      .start (sel_q + 3'd1),
      .idx   (idx_next),
      .found (found_next)
   );

   Mux8Way16 u_mux (
      .a   (d0),
      .b   (d1),
      .c   (d2),
      .d   (d3),
      .e   (d4),
      .f   (d5),
      .g   (d6),
      .h   (d7),
      .sel (sel_q),
      .out (mux_out)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (found_idle) begin
               gnt_d       = onehot8(idx_idle);
               sel_d       = idx_idle;
               last_d      = idx_idle;
               burst_cnt_d = 4'd1;
               state_d     = S_GRANT;
            end
         end
         S_GRANT: begin
            if (req[sel_q] && (burst_cnt_q < MAX_B)) begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end else if (found_next) begin
               gnt_d       = onehot8(idx_next);
               sel_d       = idx_next;
               last_d      = idx_next;
               burst_cnt_d = 4'd1;
            end else if (req[sel_q]) begin
               burst_cnt_d = 4'd1;
            end else begin
               gnt_d       = '0;
               burst_cnt_d = '0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            gnt_d       = '0;
            burst_cnt_d = '0;
            state_d     = S_IDLE;
         end
      endcase

      out_valid_d = |gnt_q;
      out_d       = (|gnt_q) ? mux_out : out_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         sel_q       <= '0;
         last_q      <= 3'd7;
         burst_cnt_q <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = |gnt_q;

endmodule
